// File: rtl/l1_buyruk_bellegi.sv
// Direct-mapped read-only L1 instruction memory. Hits are answered combinationally;
// a miss fetches the whole line over the request/word-stream port, then answers.
module l1_buyruk_bellegi #(
   parameter int unsigned SATIR_SAYISI = 64,
   parameter int unsigned SATIR_KELIME = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cek_chip_select_n_i,
   input  logic [31:0] cek_adres_i,
   output logic        cek_bekle_o,
   output logic [31:0] cek_deger_o,
   input  logic        gecersiz_kil_i,
   output logic        ana_istek_o,
   output logic [31:0] ana_adres_o,
   input  logic        ana_hazir_i,
   input  logic        ana_gecerli_i,
   input  logic [31:0] ana_deger_i
);

   localparam int unsigned OFS   = $clog2(SATIR_KELIME);
   localparam int unsigned IDX   = $clog2(SATIR_SAYISI);
   localparam int unsigned LSB   = OFS + 2;
   localparam int unsigned TAG_W = 32 - IDX - LSB;

   localparam logic [1:0] BOSTA  = 2'd0;
   localparam logic [1:0] ISTEK  = 2'd1;
   localparam logic [1:0] DOLDUR = 2'd2;
   localparam logic [1:0] TAMAM  = 2'd3;

   logic [1:0]              durum, durum_d;
   logic [OFS-1:0]          sayac, sayac_d;
   logic [SATIR_SAYISI-1:0] gecerli, gecerli_d;
   logic                    bekleyen, bekleyen_d;
   logic                    istek_d;
   logic [31:0]             adres_d;
   logic                    veri_yaz, etiket_yaz;

   logic [31:0]      veri   [SATIR_SAYISI*SATIR_KELIME];
   logic [TAG_W-1:0] etiket [SATIR_SAYISI];

   logic [OFS-1:0]   cek_ofs;
   logic [IDX-1:0]   cek_idx, dol_idx;
   logic [TAG_W-1:0] cek_tag, dol_tag;
   logic             isabet;
   logic             adres_unused;

   assign cek_ofs      = cek_adres_i[OFS+1:2];
   assign cek_idx      = cek_adres_i[OFS+IDX+1:LSB];
   assign cek_tag      = cek_adres_i[31:OFS+IDX+2];
   assign adres_unused = ^cek_adres_i[1:0];

   // The fill targets the latched line address so the core may drop chip select mid-fill.
   assign dol_idx = ana_adres_o[OFS+IDX+1:LSB];
   assign dol_tag = ana_adres_o[31:OFS+IDX+2];

   assign isabet      = gecerli[cek_idx] && (etiket[cek_idx] == cek_tag);
   assign cek_bekle_o = !cek_chip_select_n_i && !((durum == BOSTA) && isabet);
   assign cek_deger_o = veri[{cek_idx, cek_ofs}];

   // Next-state and registered-output logic
   always_comb begin
      durum_d    = durum;
      sayac_d    = sayac;
      gecerli_d  = gecerli;
      bekleyen_d = bekleyen;
      istek_d    = ana_istek_o;
      adres_d    = ana_adres_o;
      veri_yaz   = 1'b0;
      etiket_yaz = 1'b0;
      case (durum)
         BOSTA: begin
            if (gecersiz_kil_i) gecerli_d = '0;
            if (!cek_chip_select_n_i && !isabet) begin
               adres_d = {cek_tag, cek_idx, LSB'(0)};
               sayac_d = '0;
               istek_d = 1'b1;
               durum_d = ISTEK;
            end
         end
         ISTEK: begin
            if (gecersiz_kil_i) bekleyen_d = 1'b1;
            if (ana_hazir_i) begin
               istek_d = 1'b0;
               durum_d = DOLDUR;
            end
         end
         DOLDUR: begin
            if (gecersiz_kil_i) bekleyen_d = 1'b1;
            if (ana_gecerli_i) begin
               veri_yaz = 1'b1;
               sayac_d  = sayac + OFS'(1);
               if (sayac == OFS'(SATIR_KELIME - 1)) durum_d = TAMAM;
            end
         end
         TAMAM: begin
            etiket_yaz = 1'b1;
            // A flush seen during the fill wins over installing the new line.
            if (bekleyen || gecersiz_kil_i) gecerli_d = '0;
            else                            gecerli_d[dol_idx] = 1'b1;
            bekleyen_d = 1'b0;
            durum_d    = BOSTA;
         end
         default: durum_d = BOSTA;
      endcase
   end

   // Control state with asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum       <= BOSTA;
         sayac       <= '0;
         gecerli     <= '0;
         bekleyen    <= 1'b0;
         ana_istek_o <= 1'b0;
         ana_adres_o <= '0;
      end else begin
         durum       <= durum_d;
         sayac       <= sayac_d;
         gecerli     <= gecerli_d;
         bekleyen    <= bekleyen_d;
         ana_istek_o <= istek_d;
         ana_adres_o <= adres_d;
      end
   end

   // Data and tag arrays carry no reset; the valid bits guard them.
   always_ff @(posedge clk_i) begin
      if (veri_yaz)   veri[{dol_idx, sayac}] <= ana_deger_i;
      if (etiket_yaz) etiket[dol_idx]        <= dol_tag;
   end

endmodule

// File: tb/tb_l1_buyruk_bellegi.sv
// Directed bench for l1_buyruk_bellegi with a word-stream main-memory model
// and a queue of expected fetch words.
module tb_l1_buyruk_bellegi;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cs_n;
   logic [31:0] adres;
   logic        cek_bekle_o;
   logic [31:0] cek_deger_o;
   logic        gk;
   logic        ana_istek_o;
   logic [31:0] ana_adres_o;
   logic        hazir;
   logic        gec;
   logic [31:0] mdeger;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   int          mm_gecikme = 0;
   int          mm_bosluk  = 0;
   int          mm_st      = 0;
   int          mm_cnt     = 0;
   int          mm_gap     = 0;
   int          mm_word    = 0;
   int          mm_fills   = 0;
   logic [31:0] mm_base    = '0;

   l1_buyruk_bellegi dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .cek_chip_select_n_i (cs_n),
      .cek_adres_i         (adres),
      .cek_bekle_o         (cek_bekle_o),
      .cek_deger_o         (cek_deger_o),
      .gecersiz_kil_i      (gk),
      .ana_istek_o         (ana_istek_o),
      .ana_adres_o         (ana_adres_o),
      .ana_hazir_i         (hazir),
      .ana_gecerli_i       (gec),
      .ana_deger_i         (mdeger)
   );

   always #5 clk_i = ~clk_i;

   // Main-memory contents
   function automatic logic [31:0] mdl(input logic [31:0] a);
      logic [31:0] base;
      logic [31:0] ofs;
      base = a & 32'hFFFF_FFF0;
      ofs  = (a >> 2) & 32'h3;
      if (base == 32'h100) return 32'hA0 + ofs;
      if (base == 32'h500) return 32'hB0 + ofs;
      return (a & 32'hFFFF_FFFC) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory model: optional accept delay, then words with optional idle gaps
   initial begin
      hazir  = 1'b0;
      gec    = 1'b0;
      mdeger = '0;
      forever begin
         @(negedge clk_i);
         hazir = 1'b0;
         gec   = 1'b0;
         if (rst_i) begin
            mm_st  = 0;
            mm_cnt = 0;
         end else if (mm_st == 0) begin
            if (ana_istek_o) begin
               if (mm_cnt < mm_gecikme) mm_cnt++;
               else begin
                  hazir   = 1'b1;
                  mm_cnt  = 0;
                  mm_base = ana_adres_o;
                  mm_word = 0;
                  mm_gap  = 0;
                  mm_fills++;
                  mm_st   = 2;
               end
            end
         end else begin
            if (mm_gap > 0) mm_gap--;
            else begin
               gec    = 1'b1;
               mdeger = mdl(mm_base + 32'(4 * mm_word));
               mm_word++;
               mm_gap = mm_bosluk;
               if (mm_word == 4) mm_st = 0;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the word is delivered.
   task automatic fetch(input logic [31:0] a, input int exp_wait, input int exp_fills,
                        input bit flush_mid);
      int w;
      int f0;
      bit pulsed;
      w      = 0;
      f0     = mm_fills;
      pulsed = 1'b0;
      cs_n   = 1'b0;
      adres  = a;
      sb.push_back(mdl(a));
      @(negedge clk_i);
      while (cek_bekle_o && w < 300) begin
         if (ana_istek_o) chk("ana_adres_stable", ana_adres_o, a & 32'hFFFF_FFF0);
         if (w == 1) chk("istek_cycle1", 32'(ana_istek_o), 32'd1);
         if (flush_mid && !pulsed && mm_st == 2) begin
            gk     = 1'b1;
            pulsed = 1'b1;
         end else gk = 1'b0;
         w++;
         @(negedge clk_i);
      end
      gk = 1'b0;
      chk("bekle_done", 32'(cek_bekle_o), 32'd0);
      chk("istek_idle", 32'(ana_istek_o), 32'd0);
      chk("deger", cek_deger_o, sb.pop_front());
      if (exp_wait >= 0) chk("wait_cycles", 32'(w), 32'(exp_wait));
      chk("fill_count", 32'(mm_fills - f0), 32'(exp_fills));
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_i = 1'b1;
      cs_n  = 1'b1;
      adres = '0;
      gk    = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_istek", 32'(ana_istek_o), 32'd0);
      chk("rst_adres", ana_adres_o, 32'd0);
      chk("rst_bekle_cs_hi", 32'(cek_bekle_o), 32'd0);
      cs_n  = 1'b0;
      adres = 32'h100;
      @(negedge clk_i);
      chk("rst_bekle_cs_lo", 32'(cek_bekle_o), 32'd1);
      cs_n  = 1'b1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // First fill and hits within the line
      fetch(32'h100, 7, 1, 1'b0);
      fetch(32'h104, 0, 0, 1'b0);
      fetch(32'h108, 0, 0, 1'b0);
      fetch(32'h10C, 0, 0, 1'b0);

      // Conflict on index 0x10
      fetch(32'h500, 7, 1, 1'b0);
      fetch(32'h100, 7, 1, 1'b0);

      // Slow memory: accept delayed 3 cycles, 2 idle cycles between words
      mm_gecikme = 3;
      mm_bosluk  = 2;
      fetch(32'h2040, 16, 1, 1'b0);
      mm_gecikme = 0;
      mm_bosluk  = 0;
      fetch(32'h2048, 0, 0, 1'b0);
      fetch(32'h204C, 0, 0, 1'b0);

      // Flush in BOSTA coinciding with a hit
      fetch(32'h100, 0, 0, 1'b0);
      cs_n  = 1'b0;
      adres = 32'h104;
      gk    = 1'b1;
      sb.push_back(mdl(32'h104));
      @(negedge clk_i);
      chk("flush_hit_bekle", 32'(cek_bekle_o), 32'd0);
      chk("flush_hit_deger", cek_deger_o, sb.pop_front());
      @(posedge clk_i);
      #1;
      gk = 1'b0;
      fetch(32'h100, 7, 1, 1'b0);
      fetch(32'h2040, 7, 1, 1'b0);

      // Chip select high never waits
      cs_n  = 1'b1;
      adres = 32'h900;
      @(negedge clk_i);
      chk("cs_hi_bekle", 32'(cek_bekle_o), 32'd0);
      @(posedge clk_i);
      #1;

      // Flush during the fill: line not installed, refetched
      fetch(32'h500, 14, 2, 1'b1);
      fetch(32'h504, 0, 0, 1'b0);

      // Reset during word 2 of a fill
      cs_n  = 1'b0;
      adres = 32'h100;
      n     = 0;
      @(negedge clk_i);
      while (!(mm_st == 2 && mm_word == 2) && n < 50) begin
         n++;
         @(negedge clk_i);
      end
      chk("reach_word2", 32'(mm_word), 32'd2);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_istek", 32'(ana_istek_o), 32'd0);
      chk("midrst_bekle", 32'(cek_bekle_o), 32'd1);
      cs_n  = 1'b1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      fetch(32'h100, 7, 1, 1'b0);
      fetch(32'h2040, 7, 1, 1'b0);

      cs_n = 1'b1;
      repeat (2) @(posedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
